// File: rtl/fadd_pkg.sv
// Shared widths, flag bit positions and IEEE-754 single-precision classifiers
// for the adder issue/collect wrapper.
package fadd_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_ALL1 = 8'hFF;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_INF     = 1;
    localparam int FLAG_NAN     = 2;
    localparam int FLAG_INVALID = 3;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[MAN_W +: EXP_W] == EXP_ALL1) && (f[MAN_W-1:0] != '0);
    endfunction

    // Signaling NaN: quiet bit (top mantissa bit) clear
    function automatic logic is_snan(input logic [31:0] f);
        return is_nan(f) && !f[MAN_W-1];
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (f[MAN_W +: EXP_W] == EXP_ALL1) && (f[MAN_W-1:0] == '0);
    endfunction

    function automatic logic is_zero(input logic [31:0] f);
        return f[30:0] == '0;
    endfunction

endpackage

// File: rtl/fadd_result_fifo.sv
// Synchronous FIFO holding captured {result, tag, flags} entries; head is read
// straight from registered storage so outputs are stable while stalled.
module fadd_result_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop_ok;
    logic          full;

    assign valid  = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ok = pop && valid;
    assign rdata  = mem[rd_ptr];

    // Storage is cleared too so the head reads as zero out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/fadd_result_collector.sv
// Issue/collect wrapper around a fixed-latency, non-stalling FP adder: tracks
// issued ops in a delay line, captures results with flags, throttles by credit.
module fadd_result_collector
    import fadd_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic                     in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              fadd_a,
    output logic [31:0]              fadd_b,
    output logic                     fadd_op,
    input  logic [31:0]              fadd_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int FW    = 32 + TAG_W + 4;

    logic [LATENCY-1:0]            vld_pipe;
    logic [LATENCY-1:0]            inv_pipe;
    logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;

    logic             accept;
    logic             issue_inv;
    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] fifo_count;
    logic [3:0]       res_flags;
    logic [FW-1:0]    fifo_wdata, fifo_rdata;

    assign fadd_a  = in_a;
    assign fadd_b  = in_b;
    assign fadd_op = in_op;
    assign accept  = in_valid && in_ready;

    // Invalid is an operand property, so it must be decided at issue time
    assign issue_inv = is_snan(in_a) || is_snan(in_b) ||
                       (is_inf(in_a) && is_inf(in_b) && (in_a[31] ^ in_b[31] ^ in_op));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            inv_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            inv_pipe[0] <= issue_inv;
            tag_pipe[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                inv_pipe[i] <= inv_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + OCC_W'(vld_pipe[i]);
    end

    // Credit counts in-flight ops as already occupying FIFO slots
    assign occupancy = fifo_count + inflight;
    assign in_ready  = (occupancy < OCC_W'(DEPTH));

    always_comb begin
        res_flags               = '0;
        res_flags[FLAG_INVALID] = inv_pipe[LATENCY-1];
        res_flags[FLAG_NAN]     = is_nan(fadd_result);
        res_flags[FLAG_INF]     = is_inf(fadd_result);
        res_flags[FLAG_ZERO]    = is_zero(fadd_result);
    end

    assign fifo_wdata = {fadd_result, tag_pipe[LATENCY-1], res_flags};

    fadd_result_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_pipe[LATENCY-1]),
        .wdata (fifo_wdata),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .valid (out_valid),
        .count (fifo_count)
    );

    assign {out_result, out_tag, out_flags} = fifo_rdata;

endmodule

// File: tb/tb_fadd_result_collector.sv
// Bench for fadd_result_collector: fixed-latency adder stand-in plus an
// in-order scoreboard filled on accept and drained on output handshake.
module tb_fadd_result_collector;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_a = '0, in_b = '0;
    logic              in_op = 1'b0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [31:0]       fadd_a, fadd_b;
    logic              fadd_op;
    logic [31:0]       fadd_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        out_flags;
    logic [3:0]        occupancy;

    fadd_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_op(fadd_op), .fadd_result(fadd_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   run = 0;
    int   max_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Adder stand-in: known results for the directed cases, otherwise a normal number
    function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
        if (a == 32'h40000000 && b == 32'h40000000 &&  op) return 32'h00000000;
        if (a == 32'hC15A6666 && b == 32'h415A6666 && !op) return 32'h00000000;
        if (a == 32'h7FC00001 && b == 32'h41200000 && !op) return 32'h7FC00001;
        if (a == 32'h7F800000 && b == 32'h7F800000 &&  op) return 32'h7FC00000;
        if (a == 32'h7F800000 && b == 32'h3F800000 && !op) return 32'h7F800000;
        return {9'h080, a[22:0] ^ b[22:0] ^ {22'b0, op}};
    endfunction

    logic [31:0] add_pipe [LATENCY];
    initial for (int i = 0; i < LATENCY; i++) add_pipe[i] = '0;
    always @(posedge clk) begin
        add_pipe[0] <= add_model(fadd_a, fadd_b, fadd_op);
        for (int i = 1; i < LATENCY; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign fadd_result = add_pipe[LATENCY-1];

    // Scoreboard: push on accept, compare and pop on output handshake
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            run = 0;
        end else begin
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (out_valid && out_ready) begin
                pops++;
                run++;
                if (run > max_run) max_run = run;
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 64'(out_result), 64'(e.res));
                    chk("tag",    64'(out_tag),    64'(e.tag));
                    chk("flags",  64'(out_flags),  64'(e.flags));
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic [3:0] flags);
        in_a = a; in_b = b; in_op = op; in_tag = tag;
        cur_exp = '{res: res, tag: tag, flags: flags};
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic [3:0] flags);
        int n;
        set_op(a, b, op, tag, res, flags);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) chk("issue_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int pops0;
        logic acc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),   64'(1));
        chk("rst_out_valid", 64'(out_valid),  64'(0));
        chk("rst_result",    64'(out_result), 64'(0));
        chk("rst_tag",       64'(out_tag),    64'(0));
        chk("rst_flags",     64'(out_flags),  64'(0));
        chk("rst_occ",       64'(occupancy),  64'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Single add with latency check
        out_ready = 1'b1;
        set_op(32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000, 4'b0000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("occ_after_issue", 64'(occupancy), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("lat_early", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk("lat_k4", 64'(out_valid), 64'(1));
        drain();

        // Zero / sign and special values
        issue(32'h40000000, 32'h40000000, 1'b1, 4'd1, 32'h00000000, 4'b0001);
        issue(32'hC15A6666, 32'h415A6666, 1'b0, 4'd2, 32'h00000000, 4'b0001);
        issue(32'h7FC00001, 32'h41200000, 1'b0, 4'd4, 32'h7FC00001, 4'b0100);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 4'd5, 32'h7FC00000, 4'b1100);
        issue(32'h7F800000, 32'h3F800000, 1'b0, 4'd6, 32'h7F800000, 4'b0010);
        drain();

        // Backpressure: credit must stop at DEPTH accepts
        out_ready = 1'b0;
        t = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            set_op(32'h40000000 + t, 32'h3F800000, 1'b0, TAG_W'(t),
                   add_model(32'h40000000 + t, 32'h3F800000, 1'b0), 4'b0000);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) t++;
        end
        in_valid = 1'b0;
        chk("bp_accepts", 64'(t), 64'(DEPTH));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_occ", 64'(occupancy), 64'(DEPTH));
        out_ready = 1'b1;
        chk("bp_ready_same_cycle", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        chk("bp_ready_return", 64'(in_ready), 64'(1));
        drain();

        // Streaming: 16 back-to-back accepts
        pops0 = pops;
        max_run = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_op(32'h3FC00000 + i, 32'h40100000, 1'(i & 1), TAG_W'(i),
                   add_model(32'h3FC00000 + i, 32'h40100000, 1'(i & 1)), 4'b0000);
            chk("stream_ready", 64'(in_ready), 64'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        chk("stream_pops", 64'(pops - pops0), 64'(16));
        chk("stream_no_bubble", 64'(max_run), 64'(16));

        // Reset mid-flight
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(32'h40800000 + i, 32'h3F800000, 1'b0, TAG_W'(i + 9),
                   add_model(32'h40800000 + i, 32'h3F800000, 1'b0), 4'b0000);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_occ",       64'(occupancy), 64'(0));
        chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pops0 = pops;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 64'(pops - pops0), 64'(0));
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
